// File: rtl/udp_rx_ctrl_if.sv
// udp_rx_ctrl_if: receive-RAM read port and downstream FIFO write port of the UDP receive controller
interface udp_rx_ctrl_if;
    logic        udp_rec_data_valid;
    logic [15:0] udp_rec_data_length;
    logic [10:0] udp_rec_ram_read_addr;
    logic [7:0]  udp_rec_ram_rdata;
    logic [10:0] fifo_wr_count;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;

    modport master (
        input  udp_rec_data_valid, udp_rec_data_length, udp_rec_ram_rdata, fifo_wr_count,
        output udp_rec_ram_read_addr, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        output udp_rec_data_valid, udp_rec_data_length, udp_rec_ram_rdata, fifo_wr_count,
        input  udp_rec_ram_read_addr, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/udp_rx_ctrl.sv
// udp_rx_ctrl: unloads each received UDP payload from the receive RAM into the RX data FIFO
module udp_rx_ctrl #(
    parameter int FIFO_DEPTH    = 2048,
    parameter int MAX_PAYLOAD   = 1472,
    parameter int SPACE_TIMEOUT = 125_000_000
) (
    input  logic          gmii_rx_clk,
    input  logic          rst_n,
    udp_rx_ctrl_if.master bus,
    output logic          rx_busy,
    output logic          pkt_done,
    output logic [15:0]   rx_pkt_cnt,
    output logic [15:0]   rx_drop_cnt
);
    typedef enum logic [2:0] {IDLE, CHECK, WAIT_SPACE, READ, LAST} state_t;

    state_t      state, state_nxt;
    logic [15:0] len_q, pay_len, l_now, drop_inc;
    logic [11:0] free;
    logic [31:0] wait_cnt;
    logic        drop_chk, drop_to, space_chk, space_wait, last_addr, stray, drop_now;

    assign l_now      = len_q - 16'd8;
    assign free       = 12'(FIFO_DEPTH) - {1'b0, bus.fifo_wr_count};
    assign drop_chk   = (len_q < 16'd9) || (l_now > 16'(MAX_PAYLOAD));
    assign space_chk  = {4'd0, free} >= l_now;
    assign space_wait = {4'd0, free} >= pay_len;
    assign drop_to    = wait_cnt == 32'(SPACE_TIMEOUT);
    assign last_addr  = {5'd0, bus.udp_rec_ram_read_addr} == pay_len - 16'd1;
    assign stray      = bus.udp_rec_data_valid && state != IDLE;

    // state register
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state decision: length/space checks, space wait with timeout, address walk
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = bus.udp_rec_data_valid ? CHECK : IDLE;
            CHECK:      state_nxt = drop_chk ? IDLE : space_chk ? READ : WAIT_SPACE;
            WAIT_SPACE: state_nxt = space_wait ? READ : drop_to ? IDLE : WAIT_SPACE;
            READ:       state_nxt = last_addr ? LAST : READ;
            LAST:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // state-derived outputs; a stray valid and a drop in the same cycle count twice
    always_comb begin
        rx_busy  = state != IDLE;
        drop_now = (state == CHECK && drop_chk) || (state == WAIT_SPACE && !space_wait && drop_to);
        drop_inc = 16'(stray) + 16'(drop_now);
    end

    // datapath: length capture, wait timer, RAM address and the one-cycle-delayed FIFO write
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q                     <= '0;
            pay_len                   <= '0;
            wait_cnt                  <= '0;
            bus.udp_rec_ram_read_addr <= '0;
            bus.fifo_wr_en            <= 1'b0;
            bus.fifo_wr_data          <= '0;
            pkt_done                  <= 1'b0;
        end else begin
            if (state == IDLE && bus.udp_rec_data_valid) len_q <= bus.udp_rec_data_length;
            if (state == CHECK) pay_len <= l_now;
            wait_cnt                  <= state == WAIT_SPACE ? wait_cnt + 32'd1 : 32'd0;
            bus.udp_rec_ram_read_addr <= state == READ ? bus.udp_rec_ram_read_addr + 11'd1 : 11'd0;
            bus.fifo_wr_en            <= state == READ;
            bus.fifo_wr_data          <= bus.udp_rec_ram_rdata;
            pkt_done                  <= state == LAST;
        end
    end

    // accepted and dropped packet counters, both wrapping
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pkt_cnt  <= '0;
            rx_drop_cnt <= '0;
        end else begin
            rx_pkt_cnt  <= rx_pkt_cnt + 16'(state == LAST);
            rx_drop_cnt <= rx_drop_cnt + drop_inc;
        end
    end
endmodule

// File: tb/tb_udp_rx_ctrl.sv
// tb_udp_rx_ctrl: directed bench with a byte scoreboard on the FIFO write port
module tb_udp_rx_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_busy, pkt_done;
    logic [15:0] rx_pkt_cnt, rx_drop_cnt;
    int          errors = 0;
    int          checks = 0;
    int          wr_total = 0;
    int          base;
    logic [7:0]  mem [0:2047];
    logic [7:0]  exp_q [$];

    udp_rx_ctrl_if bus();

    udp_rx_ctrl #(.SPACE_TIMEOUT(100)) dut (
        .gmii_rx_clk (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .rx_busy     (rx_busy),
        .pkt_done    (pkt_done),
        .rx_pkt_cnt  (rx_pkt_cnt),
        .rx_drop_cnt (rx_drop_cnt)
    );

    always #5 clk = ~clk;

    assign bus.udp_rec_ram_rdata = mem[bus.udp_rec_ram_read_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every FIFO write must match the next expected byte
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n === 1'b1 && bus.fifo_wr_en === 1'b1) begin
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            wr_total++;
            check("wr_data", {24'd0, bus.fifo_wr_data}, {24'd0, e});
        end
    end

    task automatic load(input int n, input logic [7:0] b, input logic [7:0] s);
        for (int i = 0; i < n; i++) begin
            mem[i] = b + 8'(i) * s;
            exp_q.push_back(mem[i]);
        end
    endtask

    task automatic send(input logic [15:0] len);
        @(negedge clk);
        bus.udp_rec_data_valid  = 1'b1;
        bus.udp_rec_data_length = len;
        @(negedge clk);
        bus.udp_rec_data_valid  = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (rx_busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", rx_busy, 0);
    endtask

    initial begin
        bus.udp_rec_data_valid  = 1'b0;
        bus.udp_rec_data_length = '0;
        bus.fifo_wr_count       = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        #3;
        check("rst_addr", bus.udp_rec_ram_read_addr, 0);
        check("rst_wr_en", bus.fifo_wr_en, 0);
        check("rst_wr_data", bus.fifo_wr_data, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_done", pkt_done, 0);
        check("rst_pkt", rx_pkt_cnt, 0);
        check("rst_drop", rx_drop_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        load(4, 8'hA0, 8'd1);
        base = wr_total;
        send(16'd12);
        check("t1_busy", rx_busy, 1);
        check("t1_wr_en", bus.fifo_wr_en, 0);
        @(negedge clk);
        check("t2_addr", bus.udp_rec_ram_read_addr, 0);
        check("t2_wr_en", bus.fifo_wr_en, 0);
        @(negedge clk);
        check("t3_wr_en", bus.fifo_wr_en, 1);
        repeat (3) @(negedge clk);
        check("t6_wr_en", bus.fifo_wr_en, 1);
        @(negedge clk);
        check("t7_done", pkt_done, 1);
        check("t7_wr_en", bus.fifo_wr_en, 0);
        check("t7_pkt", rx_pkt_cnt, 1);
        check("basic_writes", wr_total - base, 4);
        @(negedge clk);
        check("t8_done", pkt_done, 0);
        check("t8_busy", rx_busy, 0);

        send(16'd8);
        @(negedge clk);
        check("len8_busy", rx_busy, 0);
        check("len8_drop", rx_drop_cnt, 1);
        send(16'd1481);
        @(negedge clk);
        check("len1481_drop", rx_drop_cnt, 2);
        load(1472, 8'd3, 8'd7);
        base = wr_total;
        send(16'd1480);
        wait_idle(1600);
        check("max_writes", wr_total - base, 1472);
        check("max_pkt", rx_pkt_cnt, 2);
        check("max_q", exp_q.size(), 0);

        bus.fifo_wr_count = 11'd2040;
        load(16, 8'h40, 8'd3);
        base = wr_total;
        send(16'd24);
        repeat (20) @(negedge clk);
        check("wait_busy", rx_busy, 1);
        check("wait_nowrite", wr_total - base, 0);
        bus.fifo_wr_count = 11'd2032;
        wait_idle(100);
        check("space_writes", wr_total - base, 16);
        check("space_pkt", rx_pkt_cnt, 3);

        bus.fifo_wr_count = 11'd2040;
        base = wr_total;
        send(16'd24);
        repeat (101) @(negedge clk);
        check("to_busy", rx_busy, 1);
        @(negedge clk);
        check("to_idle", rx_busy, 0);
        check("to_drop", rx_drop_cnt, 3);
        check("to_writes", wr_total - base, 0);
        bus.fifo_wr_count = 11'd0;

        load(64, 8'h11, 8'd5);
        base = wr_total;
        send(16'd72);
        repeat (20) @(negedge clk);
        send(16'd200);
        wait_idle(200);
        check("stray_writes", wr_total - base, 64);
        check("stray_pkt", rx_pkt_cnt, 4);
        check("stray_drop", rx_drop_cnt, 4);
        check("stray_q", exp_q.size(), 0);

        @(negedge clk);
        bus.udp_rec_data_valid  = 1'b1;
        bus.udp_rec_data_length = 16'd8;
        @(negedge clk);
        @(negedge clk);
        bus.udp_rec_data_valid  = 1'b0;
        check("dbl_drop", rx_drop_cnt, 6);
        check("dbl_busy", rx_busy, 0);

        load(100, 8'h80, 8'd1);
        send(16'd108);
        repeat (11) @(negedge clk);
        check("mid_wr_en", bus.fifo_wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr_en", bus.fifo_wr_en, 0);
        check("arst_pkt", rx_pkt_cnt, 0);
        check("arst_drop", rx_drop_cnt, 0);
        check("arst_busy", rx_busy, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        load(4, 8'h5A, 8'd2);
        base = wr_total;
        send(16'd12);
        wait_idle(20);
        check("post_writes", wr_total - base, 4);
        check("post_pkt", rx_pkt_cnt, 1);
        check("post_drop", rx_drop_cnt, 0);
        check("post_q", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/udp_rx_ctrl.md
# udp_rx_ctrl

Receive-side counterpart of the camera UDP transmit controller. It unloads each UDP payload that `mac_top` has stored in its receive RAM and pushes it byte-by-byte into a downstream write FIFO. It validates the payload length, waits for FIFO space, and keeps received and dropped packet counters. It sits between `mac_top`'s `udp_rec_*` interface and the RX data FIFO in the `gmii_rx_clk` domain.

## Interface
- `FIFO_DEPTH`, 2048: depth of the downstream FIFO in bytes.
- `MAX_PAYLOAD`, 1472: largest accepted payload in bytes.
- `SPACE_TIMEOUT`, 125_000_000: number of cycles to wait for FIFO space before dropping.
- `gmii_rx_clk` in 1: the only clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `udp_rec_data_valid` in 1: one-cycle pulse. The receive RAM holds a complete packet.
- `udp_rec_data_length` in 16: UDP length field. It includes the 8-byte UDP header.
- `udp_rec_ram_read_addr` out 11: receive RAM byte address.
- `udp_rec_ram_rdata` in 8: RAM read data. Read latency is 1 cycle.
- `fifo_wr_count` in 11: current FIFO occupancy in bytes.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_wr_data` out 8: FIFO write byte.
- `rx_busy` out 1: high whenever the state is not IDLE.
- `pkt_done` out 1: one-cycle pulse when a packet has been fully written.
- `rx_pkt_cnt` out 16: count of accepted packets. Wraps modulo 2^16.
- `rx_drop_cnt` out 16: count of dropped packets. Wraps modulo 2^16.

## Operation
- States: IDLE, CHECK, WAIT_SPACE, READ, LAST.
- Payload length is `L = udp_rec_data_length - 16'd8`. It is computed in 16 bits and registered in CHECK.
- **IDLE:** on `udp_rec_data_valid`, latch `udp_rec_data_length` and go to CHECK.
- **CHECK, drop cases:**
  - If `udp_rec_data_length < 9` (this covers underflow and L=0), drop.
  - If `L > MAX_PAYLOAD`, drop.
  - A drop increments `rx_drop_cnt` and returns to IDLE.
- **CHECK, accept cases:**
  - Free space is `FIFO_DEPTH - fifo_wr_count`, computed 12 bits wide.
  - If free space >= L, go to READ.
  - Otherwise go to WAIT_SPACE.
- **WAIT_SPACE:**
  - A 32-bit wait counter increments every cycle.
  - When free space >= L, go to READ.
  - When the counter reaches `SPACE_TIMEOUT`, drop and return to IDLE.
  - The counter is cleared in every other state.
- **READ:**
  - The address starts at 0 on entry and increments by 1 each cycle.
  - When the address equals L-1, go to LAST.
  - This gives L address cycles in total.
- **LAST:** one cycle for the final write. Then return to IDLE, pulse `pkt_done` and increment `rx_pkt_cnt`.
- **Write path:**
  - `fifo_wr_en` is a copy of the READ state delayed one cycle.
  - `fifo_wr_data` is `udp_rec_ram_rdata`, registered to align with `fifo_wr_en`.
  - Exactly L writes occur per accepted packet, in address order.
- **`udp_rec_data_valid` outside IDLE:**
  - The pulse is ignored for transfer and `rx_drop_cnt` increments.
  - The packet in progress continues unaffected.
  - If this coincides with a drop decided in CHECK, `rx_drop_cnt` increments by 2.
- `fifo_wr_count` is used as-is. Synchronisation belongs to the FIFO.

## Timing
- Reset values:
  - State is IDLE.
  - `udp_rec_ram_read_addr` = 0.
  - `fifo_wr_en` = 0 and `fifo_wr_data` = 0.
  - `rx_busy` = 0 and `pkt_done` = 0.
  - Both counters = 0.
- Reset asserted mid-packet aborts immediately. No further writes occur and the counters clear.
- Example cycle sequence (T0 is the cycle where `udp_rec_data_valid` is sampled high, with sufficient space):
  - T0: valid sampled in IDLE.
  - T1: CHECK.
  - T2 .. T2+L-1: READ, with address = 0 .. L-1.
  - T3 .. T2+L: `fifo_wr_en` high. Byte k is written at T3+k.
  - T2+L: LAST.
  - T2+L+1: IDLE, with `pkt_done` high for one cycle and `rx_pkt_cnt` updated.
- End-to-end latency from valid to first FIFO write is 3 cycles. The earliest next accepted valid is at T2+L+1.
- A drop in CHECK returns to IDLE at T2, with `rx_drop_cnt` updated at T2.
- A timeout drop returns to IDLE one cycle after the counter equals `SPACE_TIMEOUT`.
- `rx_busy` is high from T1 through LAST inclusive.

## Test plan
- **Basic transfer:** length=12, RAM bytes 0xA0..0xA3, `fifo_wr_count`=0 -> 4 writes A0,A1,A2,A3 at T3..T6; `pkt_done` at T7; `rx_pkt_cnt`=1.
- **Length checks:**
  - length=8 -> no writes, `rx_drop_cnt`=1.
  - length=1481 (L=1473) -> drop, count 2.
  - length=1480 (L=1472) -> 1472 writes.
- **Space wait:**
  - `fifo_wr_count`=2040 with L=16 -> state holds in WAIT_SPACE.
  - Lower the count to 2032 -> READ next cycle, 16 writes.
  - With `SPACE_TIMEOUT`=100 and the count held at 2040 -> drop after 100 cycles, zero writes.
- **Valid while busy:** second valid pulse during READ of L=64 -> all 64 writes intact, `rx_drop_cnt` +1, `rx_pkt_cnt` +1.
- **Reset mid-READ:** assert `rst_n`=0 at byte 10 of 100 -> `fifo_wr_en` low asynchronously, counters 0; a new packet after release transfers normally.
